ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Receives the PS/2 keyboard serial stream (ps2Clk/ps2Dat) inside the raycaster, reassembles 11-bit device-to-host frames and interprets make/break/extended prefixes. Produces one-cycle key-event strobes and a held-state bitmap for the movement keys, which the player-update logic samples each frame. It sits directly downstream of the keyboard serializer and upstream of the posx_f/posy_f/posa update logic.

## Interface
- FILTER_LEN, 4: consecutive identical synchronized ps2Clk samples required before the filtered level changes.
- TIMEOUT_CYCLES, 50000: idle clock50MHz cycles inside a frame before it is abandoned (1 ms at 50 MHz).
- clock50MHz  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- ps2Clk  in  1  PS/2 clock, asynchronous, idle high.
- ps2Dat  in  1  PS/2 data, asynchronous, idle high.
- scanCode  out  8  last completed non-prefix code; reset 8'h00.
- keyEvent  out  1  one-cycle strobe, scanCode/isBreak/isExtended valid; reset 0.
- isBreak  out  1  event was preceded by F0; reset 0.
- isExtended  out  1  event was preceded by E0; reset 0.
- frameError  out  1  one-cycle strobe on bad start, parity, stop or timeout; reset 0.
- keysHeld  out  4  {right,left,down,up} held bitmap; reset 4'b0000.

## Operation
- Input conditioning: 2-FF synchronizers on both lines. The filtered clock level changes only after FILTER_LEN equal samples. fallEdge is a one-cycle pulse on filtered 1->0. ps2Dat is taken from its synchronizer in the fallEdge cycle.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on fallEdge, data 0 -> DATA with bitCnt=0. Data 1 -> frameError, stay in IDLE.
  - DATA: shift in LSB first, 8 bits, then -> PARITY.
  - PARITY: store the bit, -> STOP.
  - STOP: requires data 1 and odd parity (^{byte,parity}==1). Pass -> byte accepted. Fail -> frameError. Either way -> IDLE.
- Timeout: a counter clears on every fallEdge and counts while not IDLE. On reaching TIMEOUT_CYCLES: frameError, -> IDLE, partial byte discarded, prefix flags preserved.
- Prefix handling on an accepted byte:
  - E0 sets extPending.
  - F0 sets brkPending.
  - Any other byte produces keyEvent with scanCode=byte, isBreak=brkPending, isExtended=extPending, then clears both flags.
  - E0 and F0 never raise keyEvent.
  - E0,F0,xx and F0 after E0 both yield isExtended=1, isBreak=1.
- keysHeld mapping: up = 1D (W) or E0 75; down = 1B (S) or E0 72; left = 1C (A) or E0 6B; right = 23 (D) or E0 74. A make sets the bit and a break clears it. Unmapped codes still strobe keyEvent but leave keysHeld unchanged. WASD and arrows share bits, so the last event wins.
- A frameError while brkPending/extPending is set leaves the flags set. They are consumed by the next valid byte.

## Timing
- Input latency: 2 sync cycles + FILTER_LEN cycles from a ps2Clk falling transition to fallEdge.
- keyEvent, scanCode, isBreak, isExtended and keysHeld all update on the cycle after the stop-bit fallEdge. keyEvent is high for exactly 1 cycle.
- frameError is high for 1 cycle: the cycle after the offending fallEdge, or the cycle after the timeout is reached.
- scanCode/isBreak/isExtended hold their values until the next keyEvent.
- Reset has priority over everything:
  - FSM -> IDLE, counters 0, prefix flags 0, all outputs to their reset values, filter history preset to 1.
  - A frame in flight at reset is dropped silently, with no frameError.
- Prefix flags have no timeout; only reset or a consumed byte clears them.

## Structure
- Shared package ps2_pkg: FSM state enum; PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0; the eight movement scan-code constants; key-bit index constants KEY_UP=0, KEY_DOWN=1, KEY_LEFT=2, KEY_RIGHT=3.
- One sub-module, ps2_line_filter: synchronizer plus FILTER_LEN debounce plus fallEdge generation, instantiated for ps2Clk. Data uses only the 2-FF synchronizer in the parent.
- Expected size: ~200 lines of RTL.

## Test plan
- Frame 1D (bits 0,1011 1000 LSB-first, parity 1, stop 1) -> keyEvent once, scanCode=1D, isBreak=0, isExtended=0, keysHeld=4'b0001.
- Sequence F0,1D after the previous case -> no event on F0; keyEvent with scanCode=1D, isBreak=1, keysHeld=4'b0000.
- E0,74 then E0,F0,74 -> first event isExtended=1, keysHeld=4'b1000; second event isExtended=1, isBreak=1, keysHeld=4'b0000.
- Frame 1C with the parity bit flipped -> frameError one cycle after the stop edge, no keyEvent, keysHeld unchanged. A following good 1C -> keysHeld[2]=1.
- ps2Clk stalls after 4 data bits for TIMEOUT_CYCLES -> frameError exactly once, FSM in IDLE. The next complete frame 23 decodes with keysHeld[3]=1.
- reset asserted mid-frame after bit 5 -> all outputs at reset values, no frameError. The following full frame 1B decodes correctly.
- Glitch: ps2Clk low pulse shorter than FILTER_LEN cycles in IDLE -> no fallEdge, no frameError.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Movement scan codes: WASD (plain) and arrow keys (E0-prefixed)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [1:0] KEY_UP    = 2'd0;
  localparam logic [1:0] KEY_DOWN  = 2'd1;
  localparam logic [1:0] KEY_LEFT  = 2'd2;
  localparam logic [1:0] KEY_RIGHT = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } key_map_t;

  // Map a completed code (with its extended flag) onto a keysHeld bit
  function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_W:    m = '{hit: 1'b1, idx: KEY_UP};
        SC_S:    m = '{hit: 1'b1, idx: KEY_DOWN};
        SC_A:    m = '{hit: 1'b1, idx: KEY_LEFT};
        SC_D:    m = '{hit: 1'b1, idx: KEY_RIGHT};
        default: m = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    m = '{hit: 1'b1, idx: KEY_UP};
        SC_DOWN:  m = '{hit: 1'b1, idx: KEY_DOWN};
        SC_LEFT:  m = '{hit: 1'b1, idx: KEY_LEFT};
        SC_RIGHT: m = '{hit: 1'b1, idx: KEY_RIGHT};
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes an asynchronous PS/2 line, debounces it and flags falling edges.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic fall_edge
);

  localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer, preset to the idle-high level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= line_in;
      sync2 <= sync1;
    end
  end

  // Filtered level follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      level     <= 1'b1;
      cnt       <= '0;
      fall_edge <= 1'b0;
    end else begin
      fall_edge <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level     <= sync2;
        cnt       <= '0;
        fall_edge <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host frame receiver with make/break/extended decoding
// and a held-state bitmap for the movement keys.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock50MHz,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Dat,
  output logic [7:0] scanCode,
  output logic       keyEvent,
  output logic       isBreak,
  output logic       isExtended,
  output logic       frameError,
  output logic [3:0] keysHeld
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e      state;
  ps2_state_e      state_next;
  logic            fall_edge;
  logic            dat_sync1;
  logic            dat_s;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity_bit;
  logic [TO_W-1:0] to_cnt;
  logic            ext_pending;
  logic            brk_pending;
  logic            timeout_hit;
  logic            byte_ok;
  logic            frame_err;
  key_map_t        key_map;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clock50MHz),
    .reset    (reset),
    .line_in  (ps2Clk),
    .fall_edge(fall_edge)
  );

  // Data line needs only synchronizing; it is sampled on filtered clock edges
  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      dat_sync1 <= 1'b1;
      dat_s     <= 1'b1;
    end else begin
      dat_sync1 <= ps2Dat;
      dat_s     <= dat_sync1;
    end
  end

  // Frame state register
  always_ff @(posedge clock50MHz) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state, byte-accept and error detection
  always_comb begin
    state_next  = state;
    byte_ok     = 1'b0;
    frame_err   = 1'b0;
    timeout_hit = (state != ST_IDLE) && !fall_edge && (to_cnt == TO_LAST);
    case (state)
      ST_IDLE: begin
        if (fall_edge) begin
          if (!dat_s) state_next = ST_DATA;
          else        frame_err  = 1'b1;
        end
      end
      ST_DATA: begin
        if (fall_edge && bit_cnt == 3'd7) state_next = ST_PARITY;
      end
      ST_PARITY: begin
        if (fall_edge) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (fall_edge) begin
          if (dat_s && (^{shift, parity_bit})) byte_ok   = 1'b1;
          else                                frame_err = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (timeout_hit) begin
      frame_err  = 1'b1;
      state_next = ST_IDLE;
    end
  end

  // Bit shifting, parity capture and inactivity timer
  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (fall_edge || state == ST_IDLE) to_cnt <= '0;
      else                               to_cnt <= to_cnt + 1'b1;
      if (fall_edge) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shift   <= {dat_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          ST_PARITY: parity_bit <= dat_s;
          default:   ;
        endcase
      end
    end
  end

  assign key_map = map_key(ext_pending, shift);

  // Prefix tracking, event strobes and held-key bitmap
  always_ff @(posedge clock50MHz) begin
    if (reset) begin
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      scanCode    <= '0;
      keyEvent    <= 1'b0;
      isBreak     <= 1'b0;
      isExtended  <= 1'b0;
      frameError  <= 1'b0;
      keysHeld    <= '0;
    end else begin
      keyEvent   <= 1'b0;
      frameError <= frame_err;
      if (byte_ok) begin
        if (shift == PS2_PREFIX_EXT) begin
          ext_pending <= 1'b1;
        end else if (shift == PS2_PREFIX_BRK) begin
          brk_pending <= 1'b1;
        end else begin
          keyEvent    <= 1'b1;
          scanCode    <= shift;
          isBreak     <= brk_pending;
          isExtended  <= ext_pending;
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
          if (key_map.hit) keysHeld[key_map.idx] <= ~brk_pending;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed and randomized frame stimulus against a scan-code level model.
module tb_ps2_key_decoder;

  localparam int unsigned FLEN = 4;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] scan_code;
  logic       key_event;
  logic       is_break;
  logic       is_ext;
  logic       frame_error;
  logic [3:0] keys_held;

  ps2_key_decoder #(
    .FILTER_LEN    (FLEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock50MHz(clk),
    .reset     (reset),
    .ps2Clk    (ps2_clk),
    .ps2Dat    (ps2_dat),
    .scanCode  (scan_code),
    .keyEvent  (key_event),
    .isBreak   (is_break),
    .isExtended(is_ext),
    .frameError(frame_error),
    .keysHeld  (keys_held)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Pulse monitor: counts high cycles of each strobe and when they occurred
  int unsigned ev_total = 0;
  int unsigned err_total = 0;
  int unsigned ev_cyc = 0;
  int unsigned err_cyc = 0;
  always @(negedge clk) begin
    if (key_event) begin
      ev_total++;
      ev_cyc = cyc;
    end
    if (frame_error) begin
      err_total++;
      err_cyc = cyc;
    end
  end

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned last_fall = 0;

  // Reference model state
  logic       m_ext, m_brk, m_isb, m_ise;
  logic [7:0] m_code;
  logic [3:0] m_held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    tick(HALF);
    ps2_clk = 1'b0;
    last_fall = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    p = ~(^b);
    if (bad_par) p = ~p;
    send_bit(p);
    send_bit(!bad_stop);
    ps2_dat = 1'b1;
    tick(HALF);
  endtask

  function automatic int key_of(input logic ext, input logic [7:0] b);
    if (!ext) begin
      if (b == 8'h1D) return 0;
      if (b == 8'h1B) return 1;
      if (b == 8'h1C) return 2;
      if (b == 8'h23) return 3;
    end else begin
      if (b == 8'h75) return 0;
      if (b == 8'h72) return 1;
      if (b == 8'h6B) return 2;
      if (b == 8'h74) return 3;
    end
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b, output bit ev);
    int k;
    ev = 0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      ev = 1;
      m_code = b;
      m_isb = m_brk;
      m_ise = m_ext;
      k = key_of(m_ext, b);
      if (k >= 0) m_held[k] = ~m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_isb = 0; m_ise = 0; m_code = '0; m_held = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".scanCode"}, 32'(scan_code), 32'(m_code));
    chk({tag, ".isBreak"}, 32'(is_break), 32'(m_isb));
    chk({tag, ".isExtended"}, 32'(is_ext), 32'(m_ise));
    chk({tag, ".keysHeld"}, 32'(keys_held), 32'(m_held));
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int unsigned ev0, er0, lat;
    bit exp_ev, exp_err;
    ev0 = ev_total;
    er0 = err_total;
    send_frame(b, bad_par, bad_stop);
    exp_err = bad_par || bad_stop;
    exp_ev = 0;
    if (!exp_err) model_byte(b, exp_ev);
    tick(10);
    chk({tag, ".events"}, ev_total - ev0, 32'(exp_ev));
    chk({tag, ".errors"}, err_total - er0, 32'(exp_err));
    if (exp_ev) begin
      lat = ev_cyc - last_fall;
      chk({tag, ".ev_latency_ok"}, 32'(lat >= FLEN + 2 && lat <= FLEN + 5), 32'd1);
    end
    if (exp_err) begin
      lat = err_cyc - last_fall;
      chk({tag, ".err_latency_ok"}, 32'(lat >= FLEN + 2 && lat <= FLEN + 5), 32'd1);
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] pool [13];
    int unsigned ev0, er0, lat;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
             8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h5A};
    model_reset();
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    tick(5);
    chk("reset.keyEvent", 32'(key_event), 32'd0);
    chk("reset.frameError", 32'(frame_error), 32'd0);
    check_outputs("reset");
    reset = 1'b0;
    tick(20);

    do_frame("make_1D", 8'h1D, 0, 0);
    do_frame("brk_F0", 8'hF0, 0, 0);
    do_frame("brk_1D", 8'h1D, 0, 0);
    do_frame("ext_E0", 8'hE0, 0, 0);
    do_frame("ext_74", 8'h74, 0, 0);
    do_frame("eb_E0", 8'hE0, 0, 0);
    do_frame("eb_F0", 8'hF0, 0, 0);
    do_frame("eb_74", 8'h74, 0, 0);
    do_frame("badpar_1C", 8'h1C, 1, 0);
    do_frame("good_1C", 8'h1C, 0, 0);
    do_frame("badstop_1B", 8'h1B, 0, 1);
    do_frame("pfx_F0", 8'hF0, 0, 0);
    do_frame("pfx_badpar", 8'h23, 1, 0);
    do_frame("pfx_1C", 8'h1C, 0, 0);

    // Clock stalls mid-frame: one timeout error, then a clean frame decodes
    ev0 = ev_total;
    er0 = err_total;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tick(TMO + 100);
    chk("timeout.errors", err_total - er0, 32'd1);
    chk("timeout.events", ev_total - ev0, 32'd0);
    lat = err_cyc - last_fall;
    chk("timeout.latency_ok", 32'(lat >= TMO + 4 && lat <= TMO + 12), 32'd1);
    do_frame("after_to_23", 8'h23, 0, 0);

    // Short ps2Clk glitch in idle must be ignored
    ev0 = ev_total;
    er0 = err_total;
    ps2_clk = 1'b0;
    tick(FLEN - 1);
    ps2_clk = 1'b1;
    tick(40);
    chk("glitch.errors", err_total - er0, 32'd0);
    chk("glitch.events", ev_total - ev0, 32'd0);
    do_frame("after_glitch_1B", 8'h1B, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit bp, bs;
      b = pool[$urandom_range(12, 0)];
      if ($urandom_range(4, 0) == 0) b = 8'($urandom);
      bp = ($urandom_range(7, 0) == 0);
      bs = ($urandom_range(15, 0) == 0);
      do_frame("rand", b, bp, bs);
    end

    // Reset in the middle of a frame drops it silently
    ev0 = ev_total;
    er0 = err_total;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    model_reset();
    tick(2);
    chk("midreset.keyEvent", 32'(key_event), 32'd0);
    chk("midreset.frameError", 32'(frame_error), 32'd0);
    check_outputs("midreset");
    tick(TMO + 50);
    chk("midreset.errors", err_total - er0, 32'd0);
    chk("midreset.events", ev_total - ev0, 32'd0);
    do_frame("after_rst_1B", 8'h1B, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so a stuck run still terminates
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
